// File: rtl/alu_pkg.sv
// alu_pkg: ALUCtrl encodings and FSM state type shared by the iterative ALU
package alu_pkg;
    localparam logic [2:0] ALU_OR   = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_MUL  = 3'b100;
    localparam logic [2:0] ALU_DIVU = 3'b101;
    localparam logic [2:0] ALU_REMU = 3'b110;
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
endpackage

// File: rtl/alu_shift_mul.sv
// alu_shift_mul: shift-add multiplier datapath, one multiplier bit per step
// result is the accumulator including the current step, so the final step's product is visible combinationally
module alu_shift_mul #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] mcand, mplier, acc;
    assign result = mplier[0] ? acc + mcand : acc;
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
        end else if (step) begin
            acc    <= result;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end
    end
endmodule

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU with start/ready/valid handshake and iterative MUL
// Restoring DIVU/REMU divider is built only when ALU_DIV_EN is defined.
module alu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    input  logic [2:0]       ALUCtrl_i,
    output logic             ready_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             Zero_o,
    output logic             err_o
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic accept, busy, last, div_op, illegal;
    logic [WIDTH-1:0] fast_res, mul_res, div_res, res_d;

    assign accept   = start_i && state_q == IDLE;
    assign busy     = state_q == MUL || state_q == DIV;
    assign last     = cnt_q == CNT_W'(WIDTH);
    assign ready_o  = state_q == IDLE;
    assign valid_o  = state_q == DONE;
    assign Zero_o   = data_o == '0;
    assign illegal  = ALUCtrl_i > ALU_MUL && !div_op;
    // Unlisted encodings fall through to zero, which is also the illegal-op result
    assign fast_res = ALUCtrl_i == ALU_OR  ? data1_i | data2_i :
                      ALUCtrl_i == ALU_AND ? data1_i & data2_i :
                      ALUCtrl_i == ALU_ADD ? data1_i + data2_i :
                      ALUCtrl_i == ALU_SUB ? data1_i - data2_i : '0;
    assign res_d    = state_q == MUL ? mul_res : state_q == DIV ? div_res : fast_res;

    always_comb begin
        state_d = state_q == DONE ? IDLE :
                  busy            ? (last ? DONE : state_q) :
                  !accept         ? IDLE :
                  ALUCtrl_i == ALU_MUL ? MUL : div_op ? DIV : DONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_o  <= '0;
            err_o   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= accept ? CNT_W'(1) : busy ? cnt_q + CNT_W'(1) : '0;
            if (state_d == DONE && state_q != DONE) begin
                data_o <= res_d;
                err_o  <= state_q == IDLE && illegal;
            end
        end
    end

    alu_shift_mul #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk_i),
        .rst    (rst_i),
        .load   (accept),
        .step   (state_q == MUL),
        .a      (data1_i),
        .b      (data2_i),
        .result (mul_res)
    );

`ifdef ALU_DIV_EN
    logic [2:0]       op_q;
    logic [WIDTH-1:0] dvsr_q, rem_q, quo_q, rem_n, quo_n;
    logic [WIDTH:0]   trial;
    assign div_op  = ALUCtrl_i == ALU_DIVU || ALUCtrl_i == ALU_REMU;
    // Divide by zero never restores, giving all-ones quotient and the dividend as remainder
    assign trial   = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvsr_q};
    assign rem_n   = trial[WIDTH] ? {rem_q[WIDTH-2:0], quo_q[WIDTH-1]} : trial[WIDTH-1:0];
    assign quo_n   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    assign div_res = op_q == ALU_DIVU ? quo_n : rem_n;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            op_q   <= '0;
            dvsr_q <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
        end else if (accept) begin
            op_q   <= ALUCtrl_i;
            dvsr_q <= data2_i;
            rem_q  <= '0;
            quo_q  <= data1_i;
        end else if (state_q == DIV) begin
            rem_q  <= rem_n;
            quo_q  <= quo_n;
        end
    end
`else
    assign div_op  = 1'b0;
    assign div_res = '0;
`endif
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed self-checking bench for alu_iter (WIDTH=32, optional ALU_DIV_EN)
module tb_alu_iter;
    logic        clk_i = 1'b0, rst_i = 1'b1, start_i = 1'b0;
    logic [31:0] data1_i = '0, data2_i = '0;
    logic [2:0]  ALUCtrl_i = '0;
    logic        ready_o, valid_o, Zero_o, err_o;
    logic [31:0] data_o;
    int n_chk = 0, n_pass = 0;
    int lat, extra;
    logic [31:0] res;
    logic err, zero, rdy2;

    alu_iter #(.WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .data1_i(data1_i), .data2_i(data2_i),
        .ALUCtrl_i(ALUCtrl_i), .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
        .Zero_o(Zero_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit hold);
        lat = 0; res = '0; err = 1'b0; zero = 1'b0; rdy2 = 1'b1; extra = 0;
        @(negedge clk_i);
        ALUCtrl_i = op; data1_i = a; data2_i = b; start_i = 1'b1;
        for (int c = 2; c <= 100 && lat == 0; c++) begin
            @(negedge clk_i);
            if (c == 2) rdy2 = ready_o;
            if (valid_o) begin
                lat = c; res = data_o; err = err_o; zero = Zero_o; start_i = 1'b0;
            end else if (hold) begin
                data1_i = ~data1_i; data2_i = data2_i + 1; ALUCtrl_i = 3'b010;
            end else start_i = 1'b0;
        end
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            extra += int'(valid_o);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_ready", 32'(ready_o), 1);
        check("rst_valid", 32'(valid_o), 0);
        check("rst_data", data_o, 0);
        check("rst_zero", 32'(Zero_o), 1);
        check("rst_err", 32'(err_o), 0);
        rst_i = 1'b0;

        run(3'b010, 32'hFFFF_FFFF, 32'h1, 0);
        check("add_lat", lat, 2);
        check("add_data", res, 0);
        check("add_zero", 32'(zero), 1);
        check("add_err", 32'(err), 0);

        run(3'b011, 32'd5, 32'd7, 0);
        check("sub_data", res, 32'hFFFF_FFFE);
        check("sub_zero", 32'(zero), 0);

        run(3'b100, 32'h0001_0003, 32'h0000_0005, 1);
        check("mul_lat", lat, 34);
        check("mul_data", res, 32'h0005_000F);
        check("mul_busy_ready", 32'(rdy2), 0);
        check("mul_one_valid", extra, 0);

        run(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("mul_wrap", res, 32'h1);
        run(3'b100, 32'h1234_5678, 32'h100, 0);
        check("mul_shift", res, 32'h3456_7800);

        @(negedge clk_i);
        ALUCtrl_i = 3'b100; data1_i = 32'd9; data2_i = 32'd9; start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (9) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_ready", 32'(ready_o), 1);
        check("abort_valid", 32'(valid_o), 0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            extra += int'(valid_o);
        end
        check("abort_no_valid", extra, 0);

        run(3'b000, 32'hF0, 32'h0F, 0);
        check("or_data", res, 32'hFF);

        run(3'b111, 32'd5, 32'd3, 0);
        check("ill_lat", lat, 2);
        check("ill_data", res, 0);
        check("ill_err", 32'(err), 1);
        check("ill_zero", 32'(zero), 1);

        run(3'b001, 32'hC, 32'hA, 0);
        check("and_data", res, 32'h8);
        check("and_err", 32'(err), 0);

`ifdef ALU_DIV_EN
        run(3'b101, 32'd100, 32'd7, 0);
        check("divu_lat", lat, 34);
        check("divu_data", res, 32'd14);
        run(3'b110, 32'd100, 32'd7, 0);
        check("remu_data", res, 32'd2);
        run(3'b101, 32'd1234, 32'd0, 0);
        check("divu_zero_data", res, 32'hFFFF_FFFF);
        check("divu_zero_err", 32'(err), 0);
        run(3'b110, 32'd1234, 32'd0, 0);
        check("remu_zero_data", res, 32'd1234);
`else
        run(3'b101, 32'd100, 32'd7, 0);
        check("divu_off_lat", lat, 2);
        check("divu_off_err", 32'(err), 1);
        check("divu_off_data", res, 0);
        run(3'b110, 32'd100, 32'd7, 0);
        check("remu_off_err", 32'(err), 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
